bram_fifo_reader: RTL
=====================

# bram_fifo_reader

Read-side controller for a BRAM-backed FIFO with fixed read latency. Issues `fifo_pop` whenever the FIFO is non-empty and enough downstream space is reserved, tracks in-flight reads, and captures returning words into a small register skid buffer. It presents them as a standard `out_valid`/`out_ready` stream, so consumers in the memory subsystem never deal with RAM latency or pop timing.

## Interface
- `DATA_WIDTH`, 32, width of FIFO read data and output stream.
- `READ_LATENCY`, 3, cycles from a `fifo_pop` cycle to the cycle its word is on `fifo_rd_data`; must be ≥ 1.
- `BUFFER_DEPTH`, READ_LATENCY+2, skid buffer entries; must be ≥ READ_LATENCY+2 for full throughput and ≥ 1 for correctness.
- `core_clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when low, no new pops are issued; in-flight reads still land and the buffer still drains.
- `flush`  in  1  synchronous discard of the buffer and all in-flight reads.
- `fifo_empty`  in  1  FIFO empty flag; reflects all pops issued in earlier cycles.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data, valid READ_LATENCY cycles after the matching pop.
- `fifo_pop`  out  1  pop strobe to the FIFO, one word per asserted cycle.
- `out_data`  out  DATA_WIDTH  head word of the skid buffer.
- `out_valid`  out  1  the skid buffer is non-empty.
- `out_ready`  in  1  consumer accepts `out_data` on a cycle where `out_valid && out_ready`.
- `buf_count`  out  $clog2(BUFFER_DEPTH+1)  number of words currently held in the skid buffer.

## Operation
- In-flight tracker: `READ_LATENCY`-bit shift register `inflight_sr`. Each cycle, `fifo_pop` shifts in at bit 0. The MSB set means `fifo_rd_data` is valid this cycle. `inflight_cnt` equals the popcount of `inflight_sr` and is kept as a counter.
- Pop rule, combinational from registered state only: `fifo_pop = enable && !flush && !fifo_empty && (buf_count + inflight_cnt < BUFFER_DEPTH)`.
  - There is no combinational path from `out_ready` to `fifo_pop`.
  - Because every in-flight word already has a reserved slot, the buffer can never overflow.
- Capture: when the `inflight_sr` MSB is set and `flush` is low, write `fifo_rd_data` at the write pointer.
- Drain: on `out_valid && out_ready`, advance the read pointer.
- Skid buffer: circular register array with read and write pointers that wrap at `BUFFER_DEPTH`, not at a power of two.
  - `buf_count` increments on capture only, decrements on drain only, and is unchanged when both happen in the same cycle.
- `out_data` is the entry at the read pointer. It is held stable while `out_valid && !out_ready`.
- Flush, in the cycle `flush` is high:
  - `fifo_pop` is forced to 0.
  - The buffer is emptied: both pointers and `buf_count` go to 0.
  - `inflight_sr` is cleared.
  - A capture or drain in the same cycle is ignored.
  - Words already popped from the FIFO are lost; this is intended.

## Timing
- Reset values:
  - `fifo_pop` = 0 (forced low while `rst` is high).
  - `out_valid` = 0, `out_data` = 0, `buf_count` = 0.
  - `inflight_sr` = 0, both pointers = 0.
- Reset mid-operation drops all buffered and in-flight words immediately.
- Latency: for a pop in cycle t, the word is captured at the end of cycle t+READ_LATENCY and `out_valid` rises in cycle t+READ_LATENCY+1. This is READ_LATENCY+1 cycles from pop to first valid.
- Throughput: with `BUFFER_DEPTH` ≥ READ_LATENCY+2, `out_ready` held high and a non-empty FIFO, one word per cycle in steady state.
- Backpressure: with `out_ready` low, pops stop after exactly `BUFFER_DEPTH - buf_count - inflight_cnt` further pops.
- Ordering: words leave strictly in pop order, across pointer wrap and across stalls.
- `enable` deassertion takes effect in the same cycle (no pop). Reassertion resumes pops in the same cycle if the pop rule allows.

## Test plan
- Single word, READ_LATENCY=3, BUFFER_DEPTH=5: FIFO holds 0xA5, `out_ready` low.
  - Required: `fifo_pop` high for exactly 1 cycle (t0).
  - `out_valid` rises at t0+4 with `out_data`=0xA5, `buf_count`=1.
- Streaming: 20 words 0..19, `out_ready` held high.
  - Required: 20 consecutive pop cycles and 20 consecutive valid beats, in order 0..19, starting 4 cycles after the first pop.
- Backpressure: 10 words, `out_ready` low.
  - Required: exactly 5 pops, then `fifo_pop` stays 0; `buf_count` reaches 5; `out_data` = word 0.
  - Raise `out_ready`: all 10 words arrive in order, with no overflow.
- Random `out_ready` (50% duty) over 200 words, covering buffer pointer wrap.
  - Required: output sequence equals input sequence; `buf_count` never exceeds 5.
- Flush while 2 words are buffered and 3 are in flight.
  - Required: next cycle `out_valid`=0, `buf_count`=0, no capture from the dropped reads.
  - Pops resume the cycle after flush deasserts.
- `rst` asserted mid-stream, asynchronously.
  - Required: `fifo_pop`, `out_valid`, `buf_count` go to 0 immediately.
  - After release, the first new pop yields valid data READ_LATENCY+1 cycles later.

Source files
------------

// File: rtl/bram_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_fifo_reader
// Purpose  : Read-side controller for a BRAM-backed FIFO with a fixed read
//            latency. Pops the FIFO only when a skid-buffer slot is reserved
//            for the returning word, tracks in-flight reads, captures the
//            returning data and presents it as a valid/ready stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_core_clk      clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_enable        allow new pops (in-flight reads and drain are unaffected)
//   i_flush         synchronous discard of buffer and in-flight reads
//   i_fifo_empty    FIFO empty flag
//   i_fifo_rd_data  FIFO read data, READ_LATENCY cycles after its pop
//   o_fifo_pop      pop strobe, one word per asserted cycle
//   o_out_data      head word of the skid buffer
//   o_out_valid     skid buffer non-empty
//   i_out_ready     consumer accept
//   o_buf_count     words currently held in the skid buffer
// ============================================================================
module bram_fifo_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 3,
  parameter int BUFFER_DEPTH = READ_LATENCY + 2
) (
  input  logic                              i_core_clk,
  input  logic                              i_rst,
  input  logic                              i_enable,
  input  logic                              i_flush,
  input  logic                              i_fifo_empty,
  input  logic [DATA_WIDTH-1:0]             i_fifo_rd_data,
  output logic                              o_fifo_pop,
  output logic [DATA_WIDTH-1:0]             o_out_data,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0] o_buf_count
);

  localparam int                 c_CNT_W    = $clog2(BUFFER_DEPTH + 1);
  localparam int                 c_PTR_W    = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [c_CNT_W:0]   c_DEPTH    = (c_CNT_W + 1)'(BUFFER_DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(BUFFER_DEPTH - 1);

  if (READ_LATENCY < 1 || BUFFER_DEPTH < 1) begin : g_param_check
    $error("bram_fifo_reader: READ_LATENCY and BUFFER_DEPTH must be >= 1");
  end

  // In-flight tracking
  logic [READ_LATENCY-1:0] r_inflight_sr;
  logic [READ_LATENCY-1:0] w_inflight_sr_next;
  logic [c_CNT_W-1:0]      r_inflight_cnt;

  // Skid buffer
  logic [DATA_WIDTH-1:0]   r_mem [BUFFER_DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_CNT_W-1:0]      r_count;

  logic [c_CNT_W:0]        w_reserved;
  logic                    w_pop;
  logic                    w_land;
  logic                    w_capture;
  logic                    w_drain;

  function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Every popped word owns a buffer slot from the pop cycle onward, so
  // buffered plus in-flight words never exceed the depth and the buffer
  // cannot overflow. The extra bit keeps the sum from wrapping.
  assign w_reserved = {1'b0, r_count} + {1'b0, r_inflight_cnt};
  assign w_pop      = i_enable && !i_flush && !i_fifo_empty && !i_rst &&
                      (w_reserved < c_DEPTH);

  // MSB of the tracker marks the cycle the FIFO data for a past pop is valid.
  assign w_land     = r_inflight_sr[READ_LATENCY-1];
  assign w_capture  = w_land && !i_flush;
  assign w_drain    = (r_count != '0) && i_out_ready && !i_flush;

  always_comb begin
    w_inflight_sr_next    = r_inflight_sr << 1;
    w_inflight_sr_next[0] = w_pop;
  end

  always_ff @(posedge i_core_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inflight_sr  <= '0;
      r_inflight_cnt <= '0;
    end else if (i_flush) begin
      r_inflight_sr  <= '0;
      r_inflight_cnt <= '0;
    end else begin
      r_inflight_sr <= w_inflight_sr_next;
      case ({w_pop, w_land})
        2'b10:   r_inflight_cnt <= r_inflight_cnt + 1'b1;
        2'b01:   r_inflight_cnt <= r_inflight_cnt - 1'b1;
        default: r_inflight_cnt <= r_inflight_cnt;
      endcase
    end
  end

  always_ff @(posedge i_core_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_drain) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      case ({w_capture, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset so the head word reads as zero out of reset.
  always_ff @(posedge i_core_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_capture) begin
      r_mem[r_wr_ptr] <= i_fifo_rd_data;
    end
  end

  assign o_fifo_pop  = w_pop;
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_out_valid = (r_count != '0);
  assign o_buf_count = r_count;

endmodule
`default_nettype wire
